gray_step_arbiter: RTL and testbench
====================================

Name: gray_step_arbiter

Overview:
- Shares one Gray-code step counter between N_REQ requesters.
- Each request, once granted, advances the counter by exactly one Gray step. The requester receives a one-cycle Ack together with the new code.
- Round-robin arbitration, a sticky overflow flag, and a global enable.
- Sits between control units that need ordered Gray tickets and the single counter resource.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 3, Gray code width in bits (2..8).
- ID_W, 2, width of grant index; must satisfy 2^ID_W >= N_REQ.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-low reset (Reset=0 resets immediately, independent of Clk).
- En  in  1  global enable; 0 blocks new grants.
- Clr  in  1  synchronous clear of counter and Overflow.
- Req  in  N_REQ  level request per requester; held high until its Ack.
- Lock  in  N_REQ  burst hold per requester (used only with the optional feature).
- Ack  out  N_REQ  one-hot, one-cycle pulse to the serviced requester.
- Value  out  WIDTH  Gray code after the serviced step; valid while Ack!=0, otherwise holds its last value.
- GrantId  out  ID_W  index of the current/last granted requester.
- Wrap  out  1  one-cycle pulse alongside Ack when the step wrapped to zero.
- Overflow  out  1  sticky: set on any wrap, cleared by Clr or Reset.
- Busy  out  1  high in STEP state.

Behaviour:
- Reset values (Reset=0): state IDLE, internal binary count 0, Value=0, Ack=0, Wrap=0, Overflow=0, GrantId=0, round-robin pointer Ptr=0, Busy=0.
- Counter arithmetic:
  - Internal binary count B, WIDTH bits, increments mod 2^WIDTH.
  - Value = B ^ (B>>1) registered. For WIDTH=3: 000,001,011,010,110,111,101,100,000...
  - A wrap is the step from B=all-ones (Gray 100..0) to 0.
- States:
  - IDLE: if En=1 and |Req, pick the first set Req[i] searching i = Ptr, Ptr+1, ... mod N_REQ. Register GrantId=i and go to STEP. Otherwise stay in IDLE.
  - STEP (one cycle): B<=B+1; Value<=gray(B+1); Ack[GrantId]=1; Wrap=1 if B was all-ones; Overflow<=Overflow|wrap; Ptr<=GrantId+1 mod N_REQ; next state IDLE.
- Latency: Req rising in cycle t, seen while IDLE, gives Ack in cycle t+1. Throughput is one grant per 2 cycles. Ack is combinational from state and GrantId, so it is high during the STEP cycle.
- En=0 while in STEP: the step completes; En gates only new grants.
- Req dropped during STEP: Ack is still issued and the step still occurs (protocol violation, no recovery).
- Clr=1 has priority over a step:
  - B<=0, Value<=0, Overflow<=0, Wrap=0.
  - If Clr=1 during STEP, Ack is still pulsed and the reported Value is 0.
  - Ptr is unaffected.
- Wrap and Clr in the same cycle: Clr wins and Overflow ends at 0.
- Reset asserted mid-STEP: the Ack pulse is aborted and all state returns to reset values immediately.
- Requesters Req[i] with i>=N_REQ do not exist; no out-of-range grant is possible.

Optional Feature:
- Macro: GRAY_ARB_LOCK_EN.
- Defined: in STEP, if Lock[GrantId]=1, Req[GrantId]=1 and En=1, the next state is STEP again with the same GrantId. This gives back-to-back steps (one Ack per cycle), and Ptr does not advance. A burst ends on the first cycle where Lock or Req drops, or after 2^WIDTH consecutive steps, whichever comes first. The cap prevents starvation.
- Undefined: the Lock port exists but is ignored; behaviour is exactly as above.

Decomposition:
- Shared package (gray_pkg): state encoding constants ST_IDLE/ST_STEP, a bin2gray function, default WIDTH/N_REQ constants.
- One natural sub-module, gray_step_core: binary register plus gray output, with ports Step, Clr, Wrap, Value. The arbiter FSM and round-robin logic live in the top module.

Test Plan:
- Reset then single requester: Req=4'b0001 held, with each Ack dropping and re-raising Req. Required Values in order: 001,011,010,110,111,101,100,000; Wrap and Overflow=1 on the 8th Ack; Overflow stays 1 afterwards.
- Round-robin: Req=4'b1111 held constantly. Acks in order 0001,0010,0100,1000,0001, spaced 2 cycles apart; Values 001,011,010,110,111.
- Clr priority: with B=3'b111, Value=100, Overflow=1, assert Clr in the STEP cycle. Required: Ack pulses, Value=000, Wrap=0, Overflow=0; the next grant gives Value=001.
- En gating: set En=0 with Req=4'b0100 held. No Ack for 10 cycles. Raise En and Ack[2] arrives 2 cycles later with the next Gray code.
- Async reset mid-STEP: drop Reset between clock edges during STEP. Ack, Value and Overflow go to 0 immediately, before the next edge; after release, the first grant goes to requester 0 (Ptr=0).
- GRAY_ARB_LOCK_EN: Lock[1]=1 and Req=4'b0011. Four consecutive single-cycle Acks to requester 1 with Values 001,011,010,110. Drop Lock: requester 0 is granted next.

Source files
------------

// File: rtl/gray_pkg.sv
// gray_pkg
// Shared definitions for the Gray step arbiter slice: default sizing
// constants, the two-state FSM encoding and the binary-to-Gray helper.
// No ports; imported by gray_step_core and gray_step_arbiter.
package gray_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 3;
  localparam int DEF_ID_W  = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_STEP = 1'b1
  } state_t;

  // Converts a binary value to its reflected Gray code. The helper is
  // fixed at 8 bits, which is the widest counter supported; callers
  // zero-extend on the way in and truncate on the way out.
  function automatic logic [7:0] bin2gray(input logic [7:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray_step_arbiter_if.sv
// gray_step_arbiter_if
// Bundles the requester-facing signals of the Gray step arbiter.
//   Req      : level request per requester, held until its Ack
//   Lock     : burst hold per requester
//   Ack      : one-hot, one-cycle service pulse
//   Value    : Gray code after the serviced step
//   GrantId  : index of the current/last granted requester
//   Wrap     : pulse alongside Ack when the step wrapped to zero
//   Overflow : sticky wrap flag
//   Busy     : high while a step is being performed
// Modports: master = requester side, slave = arbiter side.
interface gray_step_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 3,
  parameter int ID_W  = 2
);

  logic [N_REQ-1:0] Req;
  logic [N_REQ-1:0] Lock;
  logic [N_REQ-1:0] Ack;
  logic [WIDTH-1:0] Value;
  logic [ID_W-1:0]  GrantId;
  logic             Wrap;
  logic             Overflow;
  logic             Busy;

  modport master (
    output Req, Lock,
    input  Ack, Value, GrantId, Wrap, Overflow, Busy
  );

  modport slave (
    input  Req, Lock,
    output Ack, Value, GrantId, Wrap, Overflow, Busy
  );

endinterface

// File: rtl/gray_step_core.sv
// gray_step_core
// Binary step counter with a registered Gray-code view.
//   Clk   : clock, updates on posedge
//   Reset : asynchronous active-low reset
//   Step  : perform one increment this cycle
//   Clr   : synchronous clear of the counter (wins over Step)
//   Wrap  : high during a step from all-ones back to zero (not under Clr)
//   Value : Gray code of the count; during a step it already shows the
//           post-step code so the requester sees it alongside its Ack
module gray_step_core
  import gray_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Step,
  input  logic             Clr,
  output logic             Wrap,
  output logic [WIDTH-1:0] Value
);

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] gray_next;
  logic [WIDTH-1:0] value_q;

  // Next binary count and its Gray code. The step result is forwarded
  // to Value during the step cycle so Ack and Value line up; outside a
  // step Value simply holds the last registered code. A clear in the
  // step cycle reports zero and suppresses the wrap indication.
  always_comb begin
    bin_next  = bin_q + {{(WIDTH-1){1'b0}}, 1'b1};
    gray_next = WIDTH'(bin2gray(8'(bin_next)));
    Wrap      = Step && !Clr && (bin_q == {WIDTH{1'b1}});
    if (Step) begin
      Value = Clr ? '0 : gray_next;
    end else begin
      Value = value_q;
    end
  end

  // Counter and held Gray code. Clear has priority over a step.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      bin_q   <= '0;
      value_q <= '0;
    end else if (Clr) begin
      bin_q   <= '0;
      value_q <= '0;
    end else if (Step) begin
      bin_q   <= bin_next;
      value_q <= gray_next;
    end
  end

endmodule

// File: rtl/gray_step_arbiter.sv
// gray_step_arbiter
// Round-robin arbiter sharing one Gray step counter among N_REQ
// requesters. Each grant costs an IDLE cycle (arbitration) and a STEP
// cycle (increment, Ack pulse), i.e. one grant per two cycles.
//   Clk   : clock, updates on posedge
//   Reset : asynchronous active-low reset
//   En    : global enable, gates new grants only
//   Clr   : synchronous clear of counter and Overflow
//   bus   : slave modport of gray_step_arbiter_if (Req, Lock, Ack,
//           Value, GrantId, Wrap, Overflow, Busy)
// Optional feature, macro GRAY_ARB_LOCK_EN: a granted requester holding
// Lock and Req keeps the FSM in STEP for back-to-back steps, capped at
// 2^WIDTH consecutive steps. Without the macro Lock is ignored.
module gray_step_arbiter
  import gray_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int ID_W  = DEF_ID_W
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                En,
  input  logic                Clr,
  gray_step_arbiter_if.slave  bus
);

  state_t          state_q;
  state_t          state_next;
  logic [ID_W-1:0] grant_q;
  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] ptr_next;
  logic [ID_W-1:0] pick_id;
  logic            pick_valid;
  logic            step;
  logic            burst_hold;
  logic            overflow_q;
  logic            wrap;

  // Round-robin search starting at the pointer. Walking the offsets from
  // the far end down lets the nearest set request overwrite the others,
  // so the first hit from Ptr wins without a priority encoder chain.
  always_comb begin
    logic [ID_W:0] idx;
    pick_valid = 1'b0;
    pick_id    = '0;
    idx        = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr_q} + (ID_W + 1)'(k);
      if (idx >= (ID_W + 1)'(N_REQ)) begin
        idx = idx - (ID_W + 1)'(N_REQ);
      end
      if (bus.Req[idx[ID_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_id    = idx[ID_W-1:0];
      end
    end
  end

`ifdef GRAY_ARB_LOCK_EN
  logic [WIDTH-1:0] burst_q;

  // A burst continues only while the owner keeps Lock and Req up with
  // the arbiter enabled. burst_q counts steps already taken in the
  // burst, so stopping at all-ones caps a burst at 2^WIDTH steps.
  always_comb begin
    burst_hold = bus.Lock[grant_q] && bus.Req[grant_q] && En &&
                 (burst_q != {WIDTH{1'b1}});
  end

  // Burst length tracking, restarted whenever a burst ends.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      burst_q <= '0;
    end else if (step && burst_hold) begin
      burst_q <= burst_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      burst_q <= '0;
    end
  end
`else
  // Without the burst feature every step is a single step.
  always_comb begin
    burst_hold = 1'b0;
  end
`endif

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // Next-state logic. En only blocks leaving IDLE; a step in progress
  // always completes.
  always_comb begin
    state_next = state_q;
    case (state_q)
      ST_IDLE: if (En && pick_valid) state_next = ST_STEP;
      ST_STEP: state_next = burst_hold ? ST_STEP : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM outputs. Ack is decoded straight from the state so it is high
  // during the STEP cycle itself and vanishes at once on reset.
  always_comb begin
    step    = (state_q == ST_STEP);
    bus.Busy = step;
    bus.Ack = '0;
    if (step) begin
      bus.Ack[grant_q] = 1'b1;
    end
  end

  // Pointer moves to the requester after the one just served.
  always_comb begin
    if (grant_q == ID_W'(N_REQ - 1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = grant_q + {{(ID_W-1){1'b0}}, 1'b1};
    end
  end

  // Grant index, round-robin pointer and sticky overflow. The pointer
  // holds during a burst so the burst owner does not lose its turn
  // order; Clr wins over a simultaneous wrap and leaves Ptr alone.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      grant_q    <= '0;
      ptr_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && state_next == ST_STEP) begin
        grant_q <= pick_id;
      end
      if (step && !burst_hold) begin
        ptr_q <= ptr_next;
      end
      if (Clr) begin
        overflow_q <= 1'b0;
      end else if (wrap) begin
        overflow_q <= 1'b1;
      end
    end
  end

  gray_step_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .Clk   (Clk),
    .Reset (Reset),
    .Step  (step),
    .Clr   (Clr),
    .Wrap  (wrap),
    .Value (bus.Value)
  );

  assign bus.Wrap     = wrap;
  assign bus.GrantId  = grant_q;
  assign bus.Overflow = overflow_q;

endmodule

// File: tb/tb_gray_step_arbiter.sv
// tb_gray_step_arbiter
// Scoreboard bench for gray_step_arbiter: each granted step pushes the
// expected Ack/GrantId/Value/Wrap when its request is driven, and a
// negedge monitor pops and compares whenever the DUT raises Ack.
// Covers reset values, single-requester wrap, round-robin order, Clr
// priority, En gating, asynchronous reset mid-step, and the Lock burst
// (macro GRAY_ARB_LOCK_EN) or its absence in the default build.
module tb_gray_step_arbiter;
  import gray_pkg::*;

  localparam int N_REQ = 4;
  localparam int WIDTH = 3;
  localparam int ID_W  = 2;

  logic Clk   = 1'b0;
  logic Reset = 1'b0;
  logic En    = 1'b0;
  logic Clr   = 1'b0;

  gray_step_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) bus ();

  gray_step_arbiter #(
    .N_REQ (N_REQ),
    .WIDTH (WIDTH),
    .ID_W  (ID_W)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .En    (En),
    .Clr   (Clr),
    .bus   (bus.slave)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [WIDTH-1:0] value;
    logic             wrap;
  } exp_t;

  exp_t expQ[$];
  exp_t cur;
  int   checks = 0;
  int   fails  = 0;
  int   expB   = 0;
  int   lat;
  int   cnt;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [WIDTH-1:0] tbGray(input int b);
    logic [WIDTH-1:0] v;
    v = WIDTH'(b);
    return v ^ (v >> 1);
  endfunction

  // Expected result of one ordinary step granted to requester id.
  task automatic pushExp(input int id);
    exp_t e;
    expB    = (expB + 1) % (1 << WIDTH);
    e.id    = ID_W'(id);
    e.value = tbGray(expB);
    e.wrap  = (expB == 0);
    expQ.push_back(e);
  endtask

  // Expected result of a step that coincides with Clr.
  task automatic pushExpClr(input int id);
    exp_t e;
    expB    = 0;
    e.id    = ID_W'(id);
    e.value = '0;
    e.wrap  = 1'b0;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [N_REQ-1:0] req, input logic [N_REQ-1:0] lock,
                               input logic en, input logic clr);
    bus.Req  = req;
    bus.Lock = lock;
    En       = en;
    Clr      = clr;
  endtask

  // Waits for the next Ack, bounded; returns the number of negedges taken.
  task automatic waitForAck(output int cycles);
    cycles = 0;
    do begin
      @(negedge Clk);
      cycles++;
    end while (bus.Ack == '0 && cycles < 20);
    if (bus.Ack == '0) checkOutput("ackTimeout", 32'd0, 32'd1);
  endtask

  task automatic singleGrant(input int id);
    int l;
    @(posedge Clk); #1;
    pushExp(id);
    applyStimulus(N_REQ'(1) << id, '0, 1'b1, 1'b0);
    waitForAck(l);
    checkOutput("grantLatency", l, 2);
    @(posedge Clk); #1;
    applyStimulus('0, '0, 1'b1, 1'b0);
  endtask

  task automatic resetPulse();
    @(posedge Clk); #1;
    Reset = 1'b0;
    applyStimulus('0, '0, 1'b1, 1'b0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    expB = 0;
    checkOutput("queueAtReset", expQ.size(), 0);
  endtask

  // Scoreboard monitor: every Ack must match the oldest expected step.
  always @(negedge Clk) begin
    if (Reset && bus.Ack != '0) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedAck", bus.Ack, 0);
      end else begin
        cur = expQ.pop_front();
        checkOutput("sbAck", bus.Ack, N_REQ'(1) << cur.id);
        checkOutput("sbGrantId", bus.GrantId, cur.id);
        checkOutput("sbValue", bus.Value, cur.value);
        checkOutput("sbWrap", bus.Wrap, cur.wrap);
        checkOutput("sbBusy", bus.Busy, 1);
      end
    end else if (Reset && bus.Wrap) begin
      checkOutput("wrapWithoutAck", bus.Wrap, 0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus('0, '0, 1'b1, 1'b0);
    #12;
    checkOutput("rstAck", bus.Ack, 0);
    checkOutput("rstValue", bus.Value, 0);
    checkOutput("rstOverflow", bus.Overflow, 0);
    checkOutput("rstGrantId", bus.GrantId, 0);
    checkOutput("rstBusy", bus.Busy, 0);
    checkOutput("rstWrap", bus.Wrap, 0);
    @(negedge Clk);
    Reset = 1'b1;

    // Single requester walks the full Gray sequence and wraps once.
    for (int n = 0; n < 8; n++) begin
      singleGrant(0);
      checkOutput("holdValue", bus.Value, tbGray(expB));
      checkOutput("singleOverflow", bus.Overflow, (n == 7));
    end
    repeat (3) @(posedge Clk);
    #1;
    checkOutput("overflowSticky", bus.Overflow, 1);

    // All requesters held: strict rotation, one grant per two cycles.
    resetPulse();
    @(posedge Clk); #1;
    pushExp(0); pushExp(1); pushExp(2); pushExp(3); pushExp(0);
    applyStimulus('1, '0, 1'b1, 1'b0);
    waitForAck(lat);
    checkOutput("rrFirstLatency", lat, 2);
    for (int i = 1; i < 5; i++) begin
      waitForAck(lat);
      checkOutput("rrSpacing", lat, 2);
    end
    @(posedge Clk); #1;
    applyStimulus('0, '0, 1'b1, 1'b0);

    // Advance to count all-ones with Overflow set, then clear mid-step.
    for (int k = 0; k < 10; k++) singleGrant(k % N_REQ);
    checkOutput("clrPreValue", bus.Value, 3'b100);
    checkOutput("clrPreOverflow", bus.Overflow, 1);
    @(posedge Clk); #1;
    pushExpClr(2);
    applyStimulus(4'b0100, '0, 1'b1, 1'b0);
    @(posedge Clk); #1;
    Clr = 1'b1;
    checkOutput("clrBusy", bus.Busy, 1);
    @(posedge Clk); #1;
    applyStimulus('0, '0, 1'b1, 1'b0);
    checkOutput("clrOverflow", bus.Overflow, 0);
    checkOutput("clrValue", bus.Value, 0);
    singleGrant(3);
    checkOutput("postClrValue", bus.Value, 3'b001);

    // En low blocks grants; raising it grants after two cycles.
    @(posedge Clk); #1;
    applyStimulus(4'b0100, '0, 1'b0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (bus.Ack != '0) cnt++;
    end
    checkOutput("enGateAcks", cnt, 0);
    @(posedge Clk); #1;
    pushExp(2);
    En = 1'b1;
    waitForAck(lat);
    checkOutput("enLatency", lat, 2);
    @(posedge Clk); #1;
    applyStimulus('0, '0, 1'b1, 1'b0);

    // Wrap again (Overflow=1, Ptr=1), then reset in the middle of a step.
    for (int k = 0; k < 7; k++) singleGrant(0);
    checkOutput("preRstOverflow", bus.Overflow, 1);
    @(posedge Clk); #1;
    applyStimulus(4'b1000, '0, 1'b1, 1'b0);
    @(posedge Clk); #2;
    checkOutput("preRstAck", bus.Ack, 4'b1000);
    Reset = 1'b0;
    #1;
    checkOutput("midRstAck", bus.Ack, 0);
    checkOutput("midRstValue", bus.Value, 0);
    checkOutput("midRstOverflow", bus.Overflow, 0);
    checkOutput("midRstBusy", bus.Busy, 0);
    checkOutput("midRstGrantId", bus.GrantId, 0);
    applyStimulus('0, '0, 1'b1, 1'b0);
    @(negedge Clk);
    Reset = 1'b1;
    expB = 0;
    @(posedge Clk); #1;
    pushExp(0);
    applyStimulus('1, '0, 1'b1, 1'b0);
    waitForAck(lat);
    checkOutput("postRstLatency", lat, 2);
    @(posedge Clk); #1;
    applyStimulus('0, '0, 1'b1, 1'b0);

`ifdef GRAY_ARB_LOCK_EN
    // Burst: four back-to-back steps for requester 1, then requester 0.
    resetPulse();
    @(posedge Clk); #1;
    pushExp(1); pushExp(1); pushExp(1); pushExp(1); pushExp(0);
    applyStimulus(4'b0010, 4'b0010, 1'b1, 1'b0);
    waitForAck(lat);
    checkOutput("burstFirstLatency", lat, 2);
    bus.Req = 4'b0011;
    for (int i = 0; i < 2; i++) begin
      waitForAck(lat);
      checkOutput("burstSpacing", lat, 1);
    end
    @(posedge Clk); #1;
    bus.Lock = '0;
    @(negedge Clk);
    checkOutput("burstAck4", bus.Ack, 4'b0010);
    waitForAck(lat);
    checkOutput("afterBurstLatency", lat, 2);
    @(posedge Clk); #1;
    applyStimulus('0, '0, 1'b1, 1'b0);
`else
    // Lock is ignored: a held Lock still yields one grant per two cycles.
    resetPulse();
    @(posedge Clk); #1;
    pushExp(1); pushExp(1);
    applyStimulus(4'b0010, 4'b0010, 1'b1, 1'b0);
    waitForAck(lat);
    checkOutput("noLockLatency", lat, 2);
    waitForAck(lat);
    checkOutput("noLockSpacing", lat, 2);
    @(posedge Clk); #1;
    applyStimulus('0, '0, 1'b1, 1'b0);
`endif

    repeat (4) @(posedge Clk);
    checkOutput("queueEmpty", expQ.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
